plane_packer: RTL and testbench
===============================

// Module: plane_packer
// PURPOSE
//  Inverse of the bit-plane slice mux: rebuilds packed pixel words from per-plane
//  colour slices. Accepts NBITS consecutive NCH-bit slices (one per plane, order 0..NBITS-1)
//  on a valid/ready stream and emits one NCH*NBITS-bit packed word plus framebuffer address.
//  Sits between the paint/stroke front end and the framebuffer write port.
// PARAMETERS
//  NCH     6    colour channels per slice (R1,G1,B1,R2,G2,B2 -> bits 5..0)
//  NBITS   4    bit planes per channel; word width = NCH*NBITS (24)
//  NPIX    2048 pixels per frame; address wraps after NPIX-1
//  ADDR_W  11   width of m_addr, must satisfy 2**ADDR_W >= NPIX
// PORTS
//  clk       in   1        clock, rising edge
//  rst_n     in   1        asynchronous active-low reset
//  clr       in   1        sync: clears err, plane counter, address counter, accumulator
//  s_valid   in   1        slice valid
//  s_ready   out  1        slice accepted when s_valid & s_ready
//  s_slice   in   NCH      slice bits; bit c = channel c at plane s_plane
//  s_plane   in   2        plane index of this slice (clog2(NBITS))
//  m_valid   out  1        packed word valid
//  m_ready   in   1        framebuffer accepts word when m_valid & m_ready
//  m_data    out  NCH*NBITS packed word
//  m_addr    out  ADDR_W   pixel address of m_data
//  m_last    out  1        m_valid & (m_addr == NPIX-1)
//  err       out  1        sticky: out-of-order slice dropped
// BEHAVIOUR
//  Reset (rst_n=0, async): m_valid=0, m_data=0, m_addr=0, err=0, exp_plane=0, acc=0.
//  Packing: acc[NBITS*c + k] <= s_slice[c] when slice for plane k accepted, all c.
//   e.g. NCH=6,NBITS=4: word[4c+3:4c] = channel c value, plane k = bit k.
//  Plane sequencing (exp_plane counter, 0..NBITS-1):
//   - s_plane==exp_plane: slice accepted, written, exp_plane++ (wraps to 0 after NBITS-1).
//   - s_plane==0 and exp_plane!=0: restart; acc cleared then plane-0 bits written,
//     exp_plane=1, err set (partial group discarded).
//   - any other mismatch: slice consumed (s_ready as normal) but dropped, err set,
//     exp_plane unchanged.
//  Completion: on accepting plane NBITS-1, next cycle m_valid=1, m_data=completed acc
//   (latency 1 clk from last-slice handshake); acc cleared, exp_plane=0.
//  Output holds m_data/m_addr stable while m_valid & !m_ready.
//  On m handshake: m_addr++ (NPIX-1 -> 0); m_valid falls unless a new word completes same cycle.
//  s_ready = !(m_valid & !m_ready & exp_plane==NBITS-1): planes 0..NBITS-2 always accepted;
//   last plane stalls only while an unconsumed word is pending (one-word skid buffer).
//  Simultaneous last-plane accept and m handshake: new word loaded, m_valid stays 1,
//   m_addr increments once; back-to-back throughput = 1 word per NBITS clocks.
//  clr: highest priority after reset; same values as reset, effective next edge; slice
//   presented in clr cycle is not accepted (s_ready=0 while clr).
//  Reset mid-group or mid-stall: all state lost, no word emitted.
// TESTING
//  T1 slices 3F,00,00,00 planes 0..3 -> one word 24'h111111, m_addr=0, err=0.
//  T2 slices 00,00,00,01 -> 24'h000008; slice 20 on plane1 only -> 24'h200000.
//  T3 m_ready=0 while 2nd group arrives -> planes 0..2 accepted, plane3 stalls
//   (s_ready=0), first word held; m_ready=1 -> both words emitted, addrs 0,1.
//  T4 planes 0,1,3 -> slice 3 dropped, err=1; then plane 0 -> restart, later word correct.
//  T5 stream NPIX words -> m_last=1 only on addr NPIX-1, next word addr 0.
//  T6 assert rst_n=0 after plane 2 with m_valid pending -> all outputs 0 immediately;
//   clr mid-group -> exp_plane=0, m_addr=0, err=0 next cycle.

Source files
------------

// File: rtl/plane_packer_if.sv
// plane_packer_if
//   Stream bundle between the paint/stroke front end, the plane packer and the
//   framebuffer write port.
//   Slice side : s_valid, s_ready, s_slice[NCH], s_plane[PLANE_W]
//   Word side  : m_valid, m_ready, m_data[NCH*NBITS], m_addr[ADDR_W], m_last
//   Modports   : slave  = packer view (consumes slices, produces words)
//                master = environment view (produces slices, consumes words)
interface plane_packer_if #(
    parameter int NCH    = 6,
    parameter int NBITS  = 4,
    parameter int ADDR_W = 11
);
    localparam int PLANE_W = (NBITS > 1) ? $clog2(NBITS) : 1;

    logic                   s_valid;
    logic                   s_ready;
    logic [NCH-1:0]         s_slice;
    logic [PLANE_W-1:0]     s_plane;
    logic                   m_valid;
    logic                   m_ready;
    logic [NCH*NBITS-1:0]   m_data;
    logic [ADDR_W-1:0]      m_addr;
    logic                   m_last;

    modport slave (
        input  s_valid, s_slice, s_plane, m_ready,
        output s_ready, m_valid, m_data, m_addr, m_last
    );

    modport master (
        output s_valid, s_slice, s_plane, m_ready,
        input  s_ready, m_valid, m_data, m_addr, m_last
    );
endinterface

// File: rtl/plane_packer.sv
// plane_packer
//   Rebuilds packed pixel words from per-plane colour slices. NBITS slices
//   (planes 0..NBITS-1) are gathered into an accumulator; the completed word is
//   emitted with its framebuffer address, which advances on every word handshake.
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     clr    : synchronous clear of all state (same values as reset)
//     bus    : plane_packer_if.slave (slice input stream, packed word output stream)
//     err    : sticky flag, set when an out-of-order slice is dropped or a
//              partial group is discarded by a plane-0 restart
module plane_packer #(
    parameter int NCH    = 6,
    parameter int NBITS  = 4,
    parameter int NPIX   = 2048,
    parameter int ADDR_W = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    plane_packer_if.slave      bus,
    output logic               err
);
    localparam int W       = NCH * NBITS;
    localparam int PLANE_W = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(NBITS - 1);
    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(NPIX - 1);

    logic [PLANE_W-1:0] exp_plane_q, exp_plane_d;
    logic [W-1:0]       acc_q, acc_d;
    logic [W-1:0]       m_data_q, m_data_d;
    logic [ADDR_W-1:0]  m_addr_q, m_addr_d;
    logic               m_valid_q, m_valid_d;
    logic               err_q, err_d;

    logic               s_ready;
    logic               accept;
    logic               m_hs;
    logic               in_order;
    logic               restart;
    logic [W-1:0]       acc_wr;

    // Only the last plane can stall: it is the one that would overwrite a
    // word still waiting for the framebuffer.
    assign s_ready  = !clr && !(m_valid_q && !bus.m_ready && exp_plane_q == LAST_PLANE);
    assign accept   = bus.s_valid && s_ready;
    assign m_hs     = m_valid_q && bus.m_ready;
    assign in_order = (bus.s_plane == exp_plane_q);
    assign restart  = !in_order && (bus.s_plane == '0);

    // Scatter the slice into bit s_plane of every channel nibble; a restart
    // starts from an empty accumulator.
    always_comb begin
        acc_wr = in_order ? acc_q : '0;
        for (int c = 0; c < NCH; c++) begin
            acc_wr[NBITS*c + int'(bus.s_plane)] = bus.s_slice[c];
        end
    end

    always_comb begin
        exp_plane_d = exp_plane_q;
        acc_d       = acc_q;
        m_data_d    = m_data_q;
        m_addr_d    = m_addr_q;
        m_valid_d   = m_valid_q;
        err_d       = err_q;

        if (m_hs) begin
            m_valid_d = 1'b0;
            m_addr_d  = (m_addr_q == LAST_ADDR) ? '0 : m_addr_q + ADDR_W'(1);
        end

        if (accept) begin
            if (in_order) begin
                if (exp_plane_q == LAST_PLANE) begin
                    m_data_d    = acc_wr;
                    m_valid_d   = 1'b1;
                    acc_d       = '0;
                    exp_plane_d = '0;
                end else begin
                    acc_d       = acc_wr;
                    exp_plane_d = exp_plane_q + PLANE_W'(1);
                end
            end else if (restart) begin
                acc_d       = acc_wr;
                exp_plane_d = PLANE_W'(1);
                err_d       = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        if (clr) begin
            exp_plane_d = '0;
            acc_d       = '0;
            m_data_d    = '0;
            m_addr_d    = '0;
            m_valid_d   = 1'b0;
            err_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_plane_q <= '0;
            acc_q       <= '0;
            m_data_q    <= '0;
            m_addr_q    <= '0;
            m_valid_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            exp_plane_q <= exp_plane_d;
            acc_q       <= acc_d;
            m_data_q    <= m_data_d;
            m_addr_q    <= m_addr_d;
            m_valid_q   <= m_valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_last  = m_valid_q && (m_addr_q == LAST_ADDR);
    assign err         = err_q;
endmodule

// File: tb/tb_plane_packer.sv
// tb_plane_packer
//   Directed bench for plane_packer: packing, stall/skid behaviour, out-of-order
//   handling, address wrap with m_last, async reset and synchronous clear.
module tb_plane_packer;
    logic clk = 1'b0;
    logic rst_n;
    logic clr;
    logic err;
    int   checks = 0;
    int   errors = 0;
    int   exp_a;

    always #5 clk = ~clk;

    plane_packer_if #(.NCH(6), .NBITS(4), .ADDR_W(11)) bus ();

    plane_packer #(.NCH(6), .NBITS(4), .NPIX(2048), .ADDR_W(11)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus.slave),
        .err   (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one slice and hold it until accepted; returns on the falling edge
    // after the handshake edge with s_valid dropped.
    task automatic send(input logic [5:0] sl, input logic [1:0] pl);
        int n;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_slice = sl;
        bus.s_plane = pl;
        #1;
        n = 0;
        while (!bus.s_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("send_timeout", 32'(n < 50), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b1;
        clr         = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_slice = '0;
        bus.s_plane = '0;
        bus.m_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_m_data",  32'(bus.m_data),  32'd0);
        check("rst_m_addr",  32'(bus.m_addr),  32'd0);
        check("rst_err",     32'(err),         32'd0);
        check("rst_m_last",  32'(bus.m_last),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_s_ready", 32'(bus.s_ready), 32'd1);

        // T1
        send(6'h3F, 2'd0); send(6'h00, 2'd1); send(6'h00, 2'd2); send(6'h00, 2'd3);
        check("t1_m_valid", 32'(bus.m_valid), 32'd1);
        check("t1_m_data",  32'(bus.m_data),  32'h111111);
        check("t1_m_addr",  32'(bus.m_addr),  32'd0);
        check("t1_err",     32'(err),         32'd0);
        @(negedge clk);
        check("t1_consumed", 32'(bus.m_valid), 32'd0);
        check("t1_addr_inc", 32'(bus.m_addr),  32'd1);

        // T2
        send(6'h00, 2'd0); send(6'h00, 2'd1); send(6'h00, 2'd2); send(6'h01, 2'd3);
        check("t2a_m_data", 32'(bus.m_data), 32'h000008);
        check("t2a_m_addr", 32'(bus.m_addr), 32'd1);
        send(6'h00, 2'd0); send(6'h20, 2'd1); send(6'h00, 2'd2); send(6'h00, 2'd3);
        check("t2b_m_data", 32'(bus.m_data), 32'h200000);
        check("t2b_m_addr", 32'(bus.m_addr), 32'd2);
        @(negedge clk);
        check("t2_addr", 32'(bus.m_addr), 32'd3);

        // T3: word held while framebuffer stalls, last plane of next group stalls
        bus.m_ready = 1'b0;
        send(6'h01, 2'd0); send(6'h00, 2'd1); send(6'h00, 2'd2); send(6'h00, 2'd3);
        check("t3_a_data", 32'(bus.m_data), 32'h000001);
        send(6'h00, 2'd0); send(6'h3F, 2'd1); send(6'h00, 2'd2);
        @(negedge clk);
        bus.s_valid = 1'b1; bus.s_slice = 6'h00; bus.s_plane = 2'd3;
        #1;
        check("t3_stall_s_ready", 32'(bus.s_ready), 32'd0);
        check("t3_hold_valid",    32'(bus.m_valid), 32'd1);
        check("t3_hold_data",     32'(bus.m_data),  32'h000001);
        check("t3_hold_addr",     32'(bus.m_addr),  32'd3);
        @(negedge clk);
        #1;
        check("t3_stall2_s_ready", 32'(bus.s_ready), 32'd0);
        check("t3_hold2_data",     32'(bus.m_data),  32'h000001);
        bus.m_ready = 1'b1;
        #1;
        check("t3_release_s_ready", 32'(bus.s_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.s_valid = 1'b0;
        check("t3_b_valid", 32'(bus.m_valid), 32'd1);
        check("t3_b_data",  32'(bus.m_data),  32'h222222);
        check("t3_b_addr",  32'(bus.m_addr),  32'd4);
        @(negedge clk);
        check("t3_drain_valid", 32'(bus.m_valid), 32'd0);
        check("t3_drain_addr",  32'(bus.m_addr),  32'd5);

        // T4: out-of-order drop, then plane-0 restart
        send(6'h3F, 2'd0); send(6'h3F, 2'd1); send(6'h3F, 2'd3);
        check("t4_err_drop",  32'(err),         32'd1);
        check("t4_no_word",   32'(bus.m_valid), 32'd0);
        send(6'h00, 2'd0); send(6'h00, 2'd1); send(6'h00, 2'd2); send(6'h3F, 2'd3);
        check("t4_m_data",  32'(bus.m_data), 32'h888888);
        check("t4_m_addr",  32'(bus.m_addr), 32'd5);
        check("t4_err_sticky", 32'(err), 32'd1);

        // clr mid-group, with a slice offered during clr
        send(6'h3F, 2'd0); send(6'h3F, 2'd1);
        @(negedge clk);
        clr = 1'b1;
        bus.s_valid = 1'b1; bus.s_slice = 6'h3F; bus.s_plane = 2'd2;
        #1;
        check("clr_s_ready", 32'(bus.s_ready), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        bus.s_valid = 1'b0;
        check("clr_err",     32'(err),         32'd0);
        check("clr_m_addr",  32'(bus.m_addr),  32'd0);
        check("clr_m_valid", 32'(bus.m_valid), 32'd0);
        send(6'h00, 2'd0); send(6'h00, 2'd1); send(6'h3F, 2'd2); send(6'h00, 2'd3);
        check("clr_m_data", 32'(bus.m_data), 32'h444444);
        check("clr_addr0",  32'(bus.m_addr), 32'd0);
        check("clr_err2",   32'(err),        32'd0);

        // T5: full frame, address wrap and m_last
        exp_a = 1;
        for (int i = 0; i < 2048; i++) begin
            send(6'h00, 2'd0); send(6'h00, 2'd1); send(6'h00, 2'd2); send(6'h00, 2'd3);
            check("t5_m_addr", 32'(bus.m_addr), 32'(exp_a));
            check("t5_m_last", 32'(bus.m_last), 32'(exp_a == 2047));
            exp_a = (exp_a + 1) % 2048;
        end
        @(negedge clk);
        check("t5_wrap_addr", 32'(bus.m_addr), 32'd1);
        check("t5_last_idle", 32'(bus.m_last), 32'd0);

        // T6: async reset while a word is pending and a group is partial
        bus.m_ready = 1'b0;
        send(6'h3F, 2'd2);
        send(6'h01, 2'd0); send(6'h00, 2'd1); send(6'h00, 2'd2); send(6'h00, 2'd3);
        send(6'h3F, 2'd0); send(6'h3F, 2'd1); send(6'h3F, 2'd2);
        @(negedge clk);
        check("t6_pre_err",   32'(err),         32'd1);
        check("t6_pre_valid", 32'(bus.m_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("t6_rst_m_data",  32'(bus.m_data),  32'd0);
        check("t6_rst_m_addr",  32'(bus.m_addr),  32'd0);
        check("t6_rst_err",     32'(err),         32'd0);
        check("t6_rst_m_last",  32'(bus.m_last),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        send(6'h00, 2'd0); send(6'h00, 2'd1); send(6'h00, 2'd2); send(6'h3F, 2'd3);
        check("t6_post_data", 32'(bus.m_data), 32'h888888);
        check("t6_post_addr", 32'(bus.m_addr), 32'd0);
        check("t6_post_err",  32'(err),        32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
